uart_tx_word: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_word.sv | 120 ++++++++++++
 tb/tb_uart_tx_word.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line-level constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, ticks on the last cycle of each bit
module uart_baud_gen #(
  parameter int COUNT = 86
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // Wrapping on tick keeps every bit exactly COUNT cycles without a restart pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_word.sv
// rtl/uart_tx_word.sv - 8N1 transmitter for 32-bit words (MSB byte first) or single bytes
module uart_tx_word
  import uart_pkg::*;
#(
  parameter int CLOCK_PERIOD      = 10_000_000,
  parameter int BAUD_RATE         = 115_200,
  parameter int BAUD_PERIOD_COUNT = CLOCK_PERIOD / BAUD_RATE
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iWORD_EN,
  input  logic [31:0] iWORD,
  input  logic        iBYTE_EN,
  input  logic [7:0]  iBYTE,
  output logic        oUART_TX,
  output logic        oBUSY,
  output logic        oOVERRUN,
  output logic        oDONE
);

  uart_state_e state, state_n;
  logic [2:0]  idx, idx_n;
  logic [2:0]  bytes, bytes_n;
  logic [31:0] shreg, shreg_n;
  logic [7:0]  cur_n;
  logic        tx_q, tx_n;
  logic        done_q, done_n;
  logic        ovr_q, ovr_n;
  logic        tick;

  // Counter is held at zero while idle so the start bit gets a full period.
  uart_baud_gen #(.COUNT(BAUD_PERIOD_COUNT)) u_baud (
    .clk     (iCLK),
    .rst_n   (iRESETn),
    .restart (state == IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    bytes_n = bytes;
    shreg_n = shreg;
    done_n  = 1'b0;
    ovr_n   = (state != IDLE) ? (iWORD_EN | iBYTE_EN) : (iWORD_EN & iBYTE_EN);
    case (state)
      IDLE: begin
        if (iWORD_EN) begin
          shreg_n = iWORD;
          bytes_n = 3'd4;
          state_n = START;
        end else if (iBYTE_EN) begin
          shreg_n = {iBYTE, 24'h0};
          bytes_n = 3'd1;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == 3'(UART_DATA_BITS - 1)) state_n = STOP;
          else idx_n = idx + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          bytes_n = bytes - 3'd1;
          if (bytes == 3'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = START;
            shreg_n = {shreg[23:0], 8'h00};
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so the output register lines up with it.
    cur_n = shreg_n[31:24];
    case (state_n)
      START:   tx_n = UART_START_BIT;
      DATA:    tx_n = cur_n[idx_n];
      STOP:    tx_n = UART_STOP_BIT;
      default: tx_n = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state  <= IDLE;
      idx    <= '0;
      bytes  <= '0;
      shreg  <= '0;
      tx_q   <= UART_IDLE_LEVEL;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      bytes  <= bytes_n;
      shreg  <= shreg_n;
      tx_q   <= tx_n;
      done_q <= done_n;
      ovr_q  <= ovr_n;
    end
  end

  assign oUART_TX = tx_q;
  assign oBUSY    = (state != IDLE);
  assign oDONE    = done_q;
  assign oOVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// tb/tb_uart_tx_word.sv - directed vector bench for uart_tx_word
module tb_uart_tx_word;

  localparam int BPC = 10;

  logic        clk;
  logic        rst_n;
  logic        word_en;
  logic [31:0] word;
  logic        byte_en;
  logic [7:0]  byte_in;
  logic        tx, busy, overrun, done;

  logic        word_en2;
  logic [31:0] word2;
  logic        byte_en2;
  logic [7:0]  byte_in2;
  logic        tx2, busy2, overrun2, done2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        wen;
    logic        ben;
    logic [31:0] w;
    logic [7:0]  b;
    logic [31:0] exp_bytes;
    int          nb;
    logic        ovr;
    int          inj;
  } vec_t;

  vec_t vecs[5];

  uart_tx_word #(.CLOCK_PERIOD(1000), .BAUD_RATE(100)) dut (
    .iCLK     (clk),
    .iRESETn  (rst_n),
    .iWORD_EN (word_en),
    .iWORD    (word),
    .iBYTE_EN (byte_en),
    .iBYTE    (byte_in),
    .oUART_TX (tx),
    .oBUSY    (busy),
    .oOVERRUN (overrun),
    .oDONE    (done)
  );

  uart_tx_word dut_dflt (
    .iCLK     (clk),
    .iRESETn  (rst_n),
    .iWORD_EN (word_en2),
    .iWORD    (word2),
    .iBYTE_EN (byte_en2),
    .iBYTE    (byte_in2),
    .oUART_TX (tx2),
    .oBUSY    (busy2),
    .oOVERRUN (overrun2),
    .oDONE    (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns at the negedge where oDONE should be seen.
  task automatic run_req(input vec_t v, input string name);
    int n, bad, p, f, b;
    logic [7:0] cur;
    logic exp_lvl, exp_ovr;
    n   = v.nb * 10 * BPC;
    bad = 0;
    word_en = v.wen;
    byte_en = v.ben;
    word    = v.w;
    byte_in = v.b;
    @(negedge clk);
    word_en = 1'b0;
    byte_en = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      if (v.inj != 0 && k == v.inj + 1) byte_en = 1'b0;
      p   = (k - 1) / BPC;
      f   = p / 10;
      b   = p % 10;
      cur = 8'(v.exp_bytes >> (24 - 8 * f));
      if (b == 0)      exp_lvl = 1'b0;
      else if (b == 9) exp_lvl = 1'b1;
      else             exp_lvl = cur[b-1];
      exp_ovr = (k == 1 && v.ovr) || (v.inj != 0 && k == v.inj + 1);
      if (tx !== exp_lvl || busy !== 1'b1 || done !== 1'b0 || overrun !== exp_ovr) bad++;
      if ((k - 1) % BPC == BPC / 2)
        check($sformatf("%s_frame%0d_bit%0d", name, f, b), 32'(tx), 32'(exp_lvl));
      if (k == 1) check({name, "_ovr_accept"}, 32'(overrun), 32'(v.ovr));
      if (v.inj != 0 && k == v.inj + 1) check({name, "_ovr_busy"}, 32'(overrun), 32'd1);
      if (v.inj != 0 && k == v.inj) begin
        byte_en = 1'b1;
        byte_in = 8'hC3;
      end
    end
    check({name, "_bad_cycles"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_line_end"}, 32'(tx), 32'd1);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_idle_done"}, 32'(done), 32'd0);
    check({name, "_idle_line"}, 32'(tx), 32'd1);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad, low, kd;
    bit seen;
    vec_t v;

    vecs[0] = '{wen: 1'b0, ben: 1'b1, w: 32'h0,         b: 8'hA5, exp_bytes: 32'hA500_0000, nb: 1, ovr: 1'b0, inj: 0};
    vecs[1] = '{wen: 1'b1, ben: 1'b0, w: 32'h1234_5678, b: 8'h00, exp_bytes: 32'h1234_5678, nb: 4, ovr: 1'b0, inj: 0};
    vecs[2] = '{wen: 1'b1, ben: 1'b1, w: 32'hDEAD_BEEF, b: 8'h33, exp_bytes: 32'hDEAD_BEEF, nb: 4, ovr: 1'b1, inj: 150};
    vecs[3] = '{wen: 1'b0, ben: 1'b1, w: 32'hFFFF_FFFF, b: 8'h00, exp_bytes: 32'h0000_0000, nb: 1, ovr: 1'b0, inj: 0};
    vecs[4] = '{wen: 1'b1, ben: 1'b0, w: 32'h00FF_8001, b: 8'hFF, exp_bytes: 32'h00FF_8001, nb: 4, ovr: 1'b0, inj: 0};

    rst_n    = 1'b0;
    word_en  = 1'b0;
    word     = '0;
    byte_en  = 1'b0;
    byte_in  = '0;
    word_en2 = 1'b0;
    word2    = '0;
    byte_en2 = 1'b0;
    byte_in2 = '0;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    check_idle("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
      check_idle($sformatf("vec%0d", i));
    end

    // Back-to-back: strobe in the oDONE cycle starts the next frame one cycle later.
    v = '{wen: 1'b0, ben: 1'b1, w: 32'h0, b: 8'h3C, exp_bytes: 32'h3C00_0000, nb: 1, ovr: 1'b0, inj: 0};
    run_req(v, "b2b_first");
    v = '{wen: 1'b0, ben: 1'b1, w: 32'h0, b: 8'hC5, exp_bytes: 32'hC500_0000, nb: 1, ovr: 1'b0, inj: 0};
    run_req(v, "b2b_second");
    check_idle("b2b");

    // Reset during DATA bit 3 of the first byte of a word.
    word_en = 1'b1;
    word    = 32'h1234_5678;
    @(negedge clk);
    word_en = 1'b0;
    repeat (44) @(negedge clk);
    check("rst_mid_pre_tx", 32'(tx), 32'd0);
    check("rst_mid_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("rst_mid_stays_idle", 32'(bad), 32'd0);
    v = '{wen: 1'b0, ben: 1'b1, w: 32'h0, b: 8'h5A, exp_bytes: 32'h5A00_0000, nb: 1, ovr: 1'b0, inj: 0};
    run_req(v, "after_rst");
    check_idle("after_rst");

    // Default parameters: 86-cycle bits, 860-cycle frame.
    byte_en2 = 1'b1;
    byte_in2 = 8'hFF;
    @(negedge clk);
    byte_en2 = 1'b0;
    low  = 0;
    kd   = 0;
    seen = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      if (k > 1) @(negedge clk);
      if (done2 === 1'b1) begin
        seen = 1'b1;
        kd   = k;
        break;
      end
      if (tx2 === 1'b0) low++;
    end
    check("dflt_done_seen", 32'(seen), 32'd1);
    check("dflt_done_cycle", 32'(kd), 32'd861);
    check("dflt_start_len", 32'(low), 32'd86);
    check("dflt_busy_end", 32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
